disk_track_buffer_ctl: RTL and testbench
========================================

# disk_track_buffer_ctl

Multi-drive track-buffer controller for the Apple II floppy path. It sits between the per-drive track requests from `apple2_top` and the MiSTer SD sector interface. For each drive it loads a whole track of sectors into that drive's region of the shared floppy DPRAM. Before replacing a modified track buffer, it writes the old track back to the image. The CPU is held in wait while any transfer is in progress.

## Interface
Parameters:
- `DRIVES`, 2: number of floppy drives served. Index width `DW = max(1,$clog2(DRIVES))`.
- `SPT`, 13: sectors per track. Sector index width `SW = $clog2(SPT)`.
- `TRACK_W`, 6: width of a track number.

Ports:
- `clk_sys`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `track`  in  DRIVES*TRACK_W: track requested by each drive. Drive d uses bits `[d*TRACK_W +: TRACK_W]`.
- `img_mounted`  in  DRIVES: one-cycle pulse per drive when an image is (re)mounted.
- `img_present`  in  DRIVES: level per drive, high when the mounted image size is nonzero.
- `track_dirty`  in  DRIVES: one-cycle pulse per drive when the controller writes that drive's buffer.
- `sd_lba`  out  32: sector address for the active request.
- `sd_rd`  out  DRIVES: one-hot read request.
- `sd_wr`  out  DRIVES: one-hot write request.
- `sd_ack`  in  DRIVES: per-drive acknowledge. High while the sector is being transferred.
- `buf_drive`  out  DW: drive whose buffer region is being accessed. This forms the upper DPRAM address bits.
- `buf_sec`  out  SW: sector within the track. This forms the middle DPRAM address bits.
- `cpu_wait`  out  1: high whenever the controller is not in IDLE.
- `track_valid`  out  DRIVES: high when the drive's buffer holds a complete track of the current image.

## Operation
Per-drive state:
- `cur_trk`: the track currently held in the buffer.
- `dirty`: set by a `track_dirty` pulse.
- `remount`: set by an `img_mounted` pulse.
- A `remount` pulse also clears `dirty`, so stale data is never written into a new image.

FSM states: IDLE, WREQ, WXFER, RREQ, RXFER.
- **IDLE**
  - Scan drives round-robin, starting after the drive served last.
  - A drive needs service if `remount` is set, or if `track_d != cur_trk_d` while `track_valid_d` is set.
  - Pick the first drive that needs service. Latch it into `buf_drive`, latch `tgt = track_d`, and set `buf_sec = 0`.
  - Clear that drive's `remount` flag.
  - If `img_present` is low: clear `track_valid`, set `cur_trk = tgt`, and stay in IDLE.
  - Otherwise, if `dirty && track_valid`: clear `dirty` and go to WREQ.
  - Otherwise: clear `track_valid` and go to RREQ.
- **WREQ / RREQ**
  - Drive `sd_lba = SPT*trk + buf_sec`. Use `trk = cur_trk` for writes and `tgt` for reads.
  - Assert `sd_wr` or `sd_rd` for the selected drive.
  - On a rising edge of `sd_ack`, drop the request and go to WXFER / RXFER.
- **WXFER / RXFER**
  - On a falling edge of `sd_ack`, check the sector index.
  - If `buf_sec == SPT-1`: set `buf_sec = 0`.
    - From WXFER, go to RREQ (the new track is loaded after write-back).
    - From RXFER, set `cur_trk = tgt`, set `track_valid`, and go to IDLE.
  - Otherwise: increment `buf_sec` and return to the matching REQ state.

Arithmetic: `SPT*trk` is computed at 32 bits with `trk` zero-extended, then `buf_sec` is added. The result is never truncated.

Boundary rules:
- A `track_dirty` pulse for the drive being serviced is ignored. Pulses for other drives are recorded.
- An `img_mounted` pulse for the drive being serviced sets `remount`. The current phase still completes, then the drive is reloaded from the next IDLE.
- A `track` change during a load does not abort it. The drive is re-serviced from IDLE afterwards.
- `sd_ack` from drives other than `buf_drive` is ignored.
- Simultaneous `remount` and `dirty` pulses on the same cycle: `remount` wins and `dirty` is cleared.
- `reset_n` low mid-transfer immediately aborts the transfer.

## Timing
- Reset values:
  - `sd_rd = 0`, `sd_wr = 0`, `sd_lba = 0`, `cpu_wait = 0`.
  - `buf_drive = 0`, `buf_sec = 0`, `track_valid = 0`.
  - All `dirty` and `remount` flags cleared; all `cur_trk` set to 0.
- Service decision: one cycle in IDLE.
- The request (`sd_rd` / `sd_wr`) and `cpu_wait` rise on the cycle after the decision.
- `sd_ack` edges are detected against a registered copy of `sd_ack`. The request drops on the cycle after the rising edge is seen.
- The next sector's request is asserted one cycle after the falling edge of `sd_ack`.
- `track_valid` rises, and `cpu_wait` falls, on the cycle after the last falling edge in RXFER.
- `buf_sec` is stable during every transfer (REQ through XFER of the same sector).

## Test plan
- **Single-drive load:** `track[5:0] = 3`, mounted, `img_present = 1`, no dirty.
  - Required: 13 reads with `sd_lba` = 39..51 and `buf_sec` = 0..12.
  - Then `track_valid[0] = 1` and `cpu_wait` low.
- **Dirty write-back:** after the track-3 load, pulse `track_dirty[0]`, then set track = 4.
  - Required: writes at lba 39..51, then reads at lba 52..64.
  - `cpu_wait` stays high throughout both phases.
- **Round-robin:** both drives request new tracks on the same cycle.
  - Required: drive 0 is served first. On the next contention, drive 1 is served first.
- **Remount during load:** `img_mounted[0]` pulsed at sector 5 of a read.
  - Required: the load completes, then all 13 sectors reload from sector 0.
  - No write occurs.
- **Empty image:** `img_present = 0` with a remount.
  - Required: no `sd_rd`, `track_valid = 0`, `cpu_wait` never asserted.
- **Async reset:** `reset_n` low during WXFER.
  - Required: `sd_rd`, `sd_wr` and `cpu_wait` are low in the same cycle, and `track_valid = 0`.
  - After release the FSM is in IDLE.

Source files
------------

// File: rtl/disk_track_buffer_ctl.sv
// Multi-drive floppy track-buffer controller: loads whole tracks from the SD image
// into per-drive DPRAM regions, writing a modified track back before replacing it.
module disk_track_buffer_ctl #(
  parameter int DRIVES  = 2,
  parameter int SPT     = 13,
  parameter int TRACK_W = 6,
  parameter int DW      = (DRIVES > 1) ? $clog2(DRIVES) : 1,
  parameter int SW      = $clog2(SPT)
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [DRIVES*TRACK_W-1:0] track,
  input  logic [DRIVES-1:0]         img_mounted,
  input  logic [DRIVES-1:0]         img_present,
  input  logic [DRIVES-1:0]         track_dirty,
  output logic [31:0]               sd_lba,
  output logic [DRIVES-1:0]         sd_rd,
  output logic [DRIVES-1:0]         sd_wr,
  input  logic [DRIVES-1:0]         sd_ack,
  output logic [DW-1:0]             buf_drive,
  output logic [SW-1:0]             buf_sec,
  output logic                      cpu_wait,
  output logic [DRIVES-1:0]         track_valid
);

  typedef enum logic [2:0] {IDLE, WREQ, WXFER, RREQ, RXFER} state_t;

  state_t              state_q;
  logic [DW-1:0]       drv_q, last_q;
  logic [SW-1:0]       sec_q;
  logic [TRACK_W-1:0]  tgt_q;
  logic [TRACK_W-1:0]  cur_trk_q [DRIVES];
  logic [DRIVES-1:0]   dirty_q, remount_q, valid_q, ack_q;
  logic                rd_q, wr_q;
  logic [31:0]         lba_q;

  logic [DRIVES-1:0]   need_d;
  logic                pick_vld_d;
  logic [DW-1:0]       pick_d;
  logic [TRACK_W-1:0]  pick_trk_d;
  logic                ack_rise, ack_fall, last_sec;

  function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] trk, input logic [SW-1:0] sec);
    return 32'(SPT) * 32'(trk) + 32'(sec);
  endfunction

  // Round-robin pick, scanning from the drive after the one served last.
  always_comb begin
    int idx;
    idx        = 0;
    need_d     = '0;
    pick_vld_d = 1'b0;
    pick_d     = '0;
    for (int d = 0; d < DRIVES; d++)
      need_d[d] = remount_q[d] || (valid_q[d] && (track[d*TRACK_W +: TRACK_W] != cur_trk_q[d]));
    for (int i = 1; i <= DRIVES; i++) begin
      idx = (int'(last_q) + i) % DRIVES;
      if (!pick_vld_d && need_d[idx]) begin
        pick_vld_d = 1'b1;
        pick_d     = DW'(idx);
      end
    end
    pick_trk_d = track[int'(pick_d)*TRACK_W +: TRACK_W];
  end

  assign ack_rise = sd_ack[drv_q] && !ack_q[drv_q];
  assign ack_fall = !sd_ack[drv_q] && ack_q[drv_q];
  assign last_sec = (sec_q == SW'(SPT-1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      drv_q     <= '0;
      last_q    <= DW'(DRIVES-1);
      sec_q     <= '0;
      tgt_q     <= '0;
      dirty_q   <= '0;
      remount_q <= '0;
      valid_q   <= '0;
      ack_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      lba_q     <= '0;
      for (int d = 0; d < DRIVES; d++) cur_trk_q[d] <= '0;
    end else begin
      ack_q <= sd_ack;
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            drv_q             <= pick_d;
            last_q            <= pick_d;
            tgt_q             <= pick_trk_d;
            sec_q             <= '0;
            remount_q[pick_d] <= 1'b0;
            if (!img_present[pick_d]) begin
              valid_q[pick_d]   <= 1'b0;
              cur_trk_q[pick_d] <= pick_trk_d;
            end else if (dirty_q[pick_d] && valid_q[pick_d]) begin
              dirty_q[pick_d] <= 1'b0;
              wr_q            <= 1'b1;
              lba_q           <= lba_of(cur_trk_q[pick_d], '0);
              state_q         <= WREQ;
            end else begin
              valid_q[pick_d] <= 1'b0;
              rd_q            <= 1'b1;
              lba_q           <= lba_of(pick_trk_d, '0);
              state_q         <= RREQ;
            end
          end
        end
        WREQ, RREQ: begin
          if (ack_rise) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            state_q <= (state_q == WREQ) ? WXFER : RXFER;
          end
        end
        WXFER: begin
          if (ack_fall) begin
            if (last_sec) begin
              sec_q   <= '0;
              rd_q    <= 1'b1;
              lba_q   <= lba_of(tgt_q, '0);
              state_q <= RREQ;
            end else begin
              sec_q   <= sec_q + SW'(1);
              wr_q    <= 1'b1;
              lba_q   <= lba_of(cur_trk_q[drv_q], sec_q + SW'(1));
              state_q <= WREQ;
            end
          end
        end
        RXFER: begin
          if (ack_fall) begin
            if (last_sec) begin
              sec_q            <= '0;
              cur_trk_q[drv_q] <= tgt_q;
              valid_q[drv_q]   <= 1'b1;
              state_q          <= IDLE;
            end else begin
              sec_q   <= sec_q + SW'(1);
              rd_q    <= 1'b1;
              lba_q   <= lba_of(tgt_q, sec_q + SW'(1));
              state_q <= RREQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Host pulses override the decision updates above; a mount always discards dirtiness.
      for (int d = 0; d < DRIVES; d++) begin
        if (img_mounted[d]) begin
          remount_q[d] <= 1'b1;
          dirty_q[d]   <= 1'b0;
        end else if (track_dirty[d] && !(state_q != IDLE && drv_q == DW'(d))) begin
          dirty_q[d] <= 1'b1;
        end
      end
    end
  end

  assign sd_lba      = lba_q;
  assign sd_rd       = rd_q ? (DRIVES'(1) << drv_q) : '0;
  assign sd_wr       = wr_q ? (DRIVES'(1) << drv_q) : '0;
  assign buf_drive   = drv_q;
  assign buf_sec     = sec_q;
  assign cpu_wait    = (state_q != IDLE);
  assign track_valid = valid_q;

endmodule

// File: tb/tb_disk_track_buffer_ctl.sv
// Directed bench for disk_track_buffer_ctl with a simple SD acknowledge model.
module tb_disk_track_buffer_ctl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [11:0] track;
  logic [1:0]  img_mounted, img_present, track_dirty, sd_ack;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic [0:0]  buf_drive;
  logic [3:0]  buf_sec;
  logic        cpu_wait;
  logic [1:0]  track_valid;

  int checks = 0;
  int errors = 0;

  disk_track_buffer_ctl dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
    .img_mounted(img_mounted), .img_present(img_present), .track_dirty(track_dirty),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .buf_drive(buf_drive), .buf_sec(buf_sec), .cpu_wait(cpu_wait), .track_valid(track_valid)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the next request, check it, then run one ack pulse for the sector.
  task automatic serve(input logic wr, input int drv, input int elba, input int esec);
    int n;
    n = 0;
    while ((sd_rd | sd_wr) == 2'b00 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("req_seen", 32'(n < 100), 1);
    chk("sd_rd", 32'(sd_rd), wr ? 0 : 32'(1 << drv));
    chk("sd_wr", 32'(sd_wr), wr ? 32'(1 << drv) : 0);
    chk("sd_lba", sd_lba, 32'(elba));
    chk("buf_sec", 32'(buf_sec), 32'(esec));
    chk("buf_drive", 32'(buf_drive), 32'(drv));
    chk("cpu_wait_busy", 32'(cpu_wait), 1);
    sd_ack[drv] = 1'b1;
    @(negedge clk_sys);
    chk("req_drop", 32'(sd_rd | sd_wr), 0);
    @(negedge clk_sys);
    chk("sec_stable", 32'(buf_sec), 32'(esec));
    sd_ack[drv] = 1'b0;
  endtask

  task automatic load(input logic wr, input int drv, input int base);
    for (int s = 0; s < 13; s++) serve(wr, drv, base + s, s);
  endtask

  task automatic pulse_mount(input int drv);
    img_mounted[drv] = 1'b1;
    @(negedge clk_sys);
    img_mounted[drv] = 1'b0;
  endtask

  initial begin
    int bad;
    reset_n = 1'b0; track = '0; img_mounted = '0; img_present = 2'b11;
    track_dirty = '0; sd_ack = '0;
    repeat (2) @(negedge clk_sys);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_cpu_wait", 32'(cpu_wait), 0);
    chk("rst_buf", 32'({buf_drive, buf_sec}), 0);
    chk("rst_valid", 32'(track_valid), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Single-drive load of track 3
    track = {6'd0, 6'd3};
    pulse_mount(0);
    load(1'b0, 0, 39);
    @(negedge clk_sys);
    chk("load_valid", 32'(track_valid), 32'b01);
    chk("load_idle", 32'(cpu_wait), 0);

    // Dirty write-back then load of track 4
    track_dirty[0] = 1'b1;
    @(negedge clk_sys);
    track_dirty[0] = 1'b0;
    track = {6'd0, 6'd4};
    load(1'b1, 0, 39);
    load(1'b0, 0, 52);
    @(negedge clk_sys);
    chk("wb_valid", 32'(track_valid), 32'b01);
    chk("wb_idle", 32'(cpu_wait), 0);

    // Drive 1 load, then round-robin contention
    track = {6'd2, 6'd4};
    pulse_mount(1);
    load(1'b0, 1, 26);
    track = {6'd7, 6'd5};
    load(1'b0, 0, 65);
    load(1'b0, 1, 91);
    track = {6'd7, 6'd6};
    load(1'b0, 0, 78);
    track = {6'd9, 6'd8};
    load(1'b0, 1, 117);
    load(1'b0, 0, 104);
    @(negedge clk_sys);
    chk("rr_valid", 32'(track_valid), 32'b11);

    // Remount at sector 5 of a load: completes, then reloads with reads only
    track = {6'd9, 6'd10};
    for (int s = 0; s < 13; s++) begin
      if (s == 5) pulse_mount(0);
      serve(1'b0, 0, 130 + s, s);
    end
    load(1'b0, 0, 130);
    @(negedge clk_sys);
    chk("remount_valid", 32'(track_valid), 32'b11);
    chk("remount_idle", 32'(cpu_wait), 0);

    // Empty image on drive 1
    img_present[1] = 1'b0;
    pulse_mount(1);
    bad = 0;
    repeat (20) begin
      if (sd_rd != 2'b00 || cpu_wait) bad++;
      @(negedge clk_sys);
    end
    chk("empty_no_activity", 32'(bad), 0);
    chk("empty_valid", 32'(track_valid), 32'b01);

    // Foreign ack ignored, then async reset during WXFER
    track_dirty[0] = 1'b1;
    @(negedge clk_sys);
    track_dirty[0] = 1'b0;
    track = {6'd9, 6'd11};
    repeat (2) @(negedge clk_sys);
    chk("wr_req", 32'(sd_wr), 32'b01);
    chk("wr_lba", sd_lba, 130);
    sd_ack[1] = 1'b1;
    @(negedge clk_sys);
    sd_ack[1] = 1'b0;
    chk("foreign_ack", 32'(sd_wr), 32'b01);
    sd_ack[0] = 1'b1;
    @(negedge clk_sys);
    chk("wxfer_wait", 32'(cpu_wait), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rd", 32'(sd_rd), 0);
    chk("arst_wr", 32'(sd_wr), 0);
    chk("arst_wait", 32'(cpu_wait), 0);
    chk("arst_valid", 32'(track_valid), 0);
    sd_ack[0] = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("post_rst_idle", 32'(cpu_wait), 0);
    chk("post_rst_req", 32'(sd_rd | sd_wr), 0);
    chk("post_rst_sec", 32'(buf_sec), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
